// File: rtl/ftq_pc_mem_writer_if.sv
// Bundle between the FTQ enqueue/pointer block and its BPU, IFU, backend and PC-memory neighbours.
// Master drives predictions, IFU/commit/redirect events; slave returns ready, write port and read addresses.
interface ftq_pc_mem_writer_if #(
    parameter int ENTRIES = 8,
    parameter int VADDR_W = 39
);
    localparam int PW = $clog2(ENTRIES);

    logic               io_enq_valid;
    logic               io_enq_ready;
    logic [VADDR_W-1:0] io_enq_startAddr;
    logic [VADDR_W-1:0] io_enq_nextLineAddr;
    logic               io_enq_fallThruError;
    logic               io_ifu_fire;
    logic               io_commit_valid;
    logic               io_redirect_valid;
    logic               io_redirect_flag;
    logic [PW-1:0]      io_redirect_value;
    logic               io_wen;
    logic [PW-1:0]      io_waddr;
    logic [VADDR_W-1:0] io_wdata_startAddr;
    logic [VADDR_W-1:0] io_wdata_nextLineAddr;
    logic               io_wdata_fallThruError;
    logic [PW-1:0]      io_ifuPtr_wvalue;
    logic [PW-1:0]      io_ifuPtrPlus1_wvalue;
    logic [PW-1:0]      io_ifuPtrPlus2_wvalue;
    logic [PW-1:0]      io_commPtr_wvalue;
    logic [PW-1:0]      io_commPtrPlus1_wvalue;
    logic               io_ifu_req_valid;
    logic [PW:0]        io_count;

    modport master (
        output io_enq_valid, io_enq_startAddr, io_enq_nextLineAddr, io_enq_fallThruError,
        output io_ifu_fire, io_commit_valid, io_redirect_valid, io_redirect_flag, io_redirect_value,
        input  io_enq_ready, io_wen, io_waddr,
        input  io_wdata_startAddr, io_wdata_nextLineAddr, io_wdata_fallThruError,
        input  io_ifuPtr_wvalue, io_ifuPtrPlus1_wvalue, io_ifuPtrPlus2_wvalue,
        input  io_commPtr_wvalue, io_commPtrPlus1_wvalue, io_ifu_req_valid, io_count
    );

    modport slave (
        input  io_enq_valid, io_enq_startAddr, io_enq_nextLineAddr, io_enq_fallThruError,
        input  io_ifu_fire, io_commit_valid, io_redirect_valid, io_redirect_flag, io_redirect_value,
        output io_enq_ready, io_wen, io_waddr,
        output io_wdata_startAddr, io_wdata_nextLineAddr, io_wdata_fallThruError,
        output io_ifuPtr_wvalue, io_ifuPtrPlus1_wvalue, io_ifuPtrPlus2_wvalue,
        output io_commPtr_wvalue, io_commPtrPlus1_wvalue, io_ifu_req_valid, io_count
    );
endinterface

// File: rtl/ftq_pc_mem_writer.sv
// FTQ PC-memory enqueue/pointer control: write issued 1 cycle after enq fire, readable by IFU 2 cycles after.
// Backpressure: enq_ready drops when all ENTRIES slots are occupied or a redirect is in progress.
module ftq_pc_mem_writer #(
    parameter int ENTRIES = 8,
    parameter int VADDR_W = 39
) (
    input logic                clock,
    input logic                reset,
    ftq_pc_mem_writer_if.slave bus
);
    localparam int PW = $clog2(ENTRIES);

    typedef struct packed {
        logic          flag;
        logic [PW-1:0] value;
    } ptr_t;

    typedef struct packed {
        logic [VADDR_W-1:0] start_addr;
        logic [VADDR_W-1:0] next_line_addr;
        logic               fall_thru_error;
    } wdata_t;

    localparam logic [PW:0] ZERO  = (PW+1)'(0);
    localparam logic [PW:0] ONE   = (PW+1)'(1);
    localparam logic [PW:0] TWO   = (PW+1)'(2);
    localparam logic [PW:0] THREE = (PW+1)'(3);

    // Flag is the carry out of the value field, so plain addition wraps correctly.
    function automatic ptr_t ptr_inc(input ptr_t p, input logic [PW:0] k);
        return ptr_t'(p + k);
    endfunction

    ptr_t   bpu_ptr, wb_ptr;
    ptr_t   ifu_ptr, ifu_ptr_p1, ifu_ptr_p2;
    ptr_t   comm_ptr, comm_ptr_p1;
    logic   wen_q;
    logic [PW-1:0] waddr_q;
    wdata_t wdata_q;

    ptr_t redir_ptr;
    logic full;
    logic enq_ready;
    logic enq_fire;
    logic ifu_req_valid;
    logic ifu_adv;
    logic commit_fire;

    assign redir_ptr     = '{flag: bus.io_redirect_flag, value: bus.io_redirect_value};
    assign full          = (bpu_ptr.value == comm_ptr.value) && (bpu_ptr.flag != comm_ptr.flag);
    assign enq_ready     = !full && !bus.io_redirect_valid;
    assign enq_fire      = bus.io_enq_valid && enq_ready;
    assign ifu_req_valid = (ifu_ptr != wb_ptr);
    assign ifu_adv       = bus.io_ifu_fire && ifu_req_valid && !bus.io_redirect_valid;
    assign commit_fire   = bus.io_commit_valid && (comm_ptr != ifu_ptr);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bpu_ptr     <= ptr_t'(ZERO);
            wb_ptr      <= ptr_t'(ZERO);
            ifu_ptr     <= ptr_t'(ZERO);
            ifu_ptr_p1  <= ptr_t'(ONE);
            ifu_ptr_p2  <= ptr_t'(TWO);
            comm_ptr    <= ptr_t'(ZERO);
            comm_ptr_p1 <= ptr_t'(ONE);
            wen_q       <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            wen_q <= enq_fire;
            if (enq_fire) begin
                waddr_q <= bpu_ptr.value;
                wdata_q <= '{start_addr:      bus.io_enq_startAddr,
                             next_line_addr:  bus.io_enq_nextLineAddr,
                             fall_thru_error: bus.io_enq_fallThruError};
            end

            // Rollback restarts fetch just after the redirecting entry; older work is kept.
            if (bus.io_redirect_valid) begin
                bpu_ptr    <= ptr_inc(redir_ptr, ONE);
                wb_ptr     <= ptr_inc(redir_ptr, ONE);
                ifu_ptr    <= ptr_inc(redir_ptr, ONE);
                ifu_ptr_p1 <= ptr_inc(redir_ptr, TWO);
                ifu_ptr_p2 <= ptr_inc(redir_ptr, THREE);
            end else begin
                if (enq_fire) begin
                    bpu_ptr <= ptr_inc(bpu_ptr, ONE);
                end
                wb_ptr <= bpu_ptr;
                if (ifu_adv) begin
                    ifu_ptr    <= ptr_inc(ifu_ptr, ONE);
                    ifu_ptr_p1 <= ptr_inc(ifu_ptr_p1, ONE);
                    ifu_ptr_p2 <= ptr_inc(ifu_ptr_p2, ONE);
                end
            end

            if (commit_fire) begin
                comm_ptr    <= ptr_inc(comm_ptr, ONE);
                comm_ptr_p1 <= ptr_inc(comm_ptr_p1, ONE);
            end
        end
    end

    assign bus.io_enq_ready           = enq_ready;
    assign bus.io_wen                 = wen_q;
    assign bus.io_waddr               = waddr_q;
    assign bus.io_wdata_startAddr     = wdata_q.start_addr;
    assign bus.io_wdata_nextLineAddr  = wdata_q.next_line_addr;
    assign bus.io_wdata_fallThruError = wdata_q.fall_thru_error;
    assign bus.io_ifuPtr_wvalue       = ifu_ptr.value;
    assign bus.io_ifuPtrPlus1_wvalue  = ifu_ptr_p1.value;
    assign bus.io_ifuPtrPlus2_wvalue  = ifu_ptr_p2.value;
    assign bus.io_commPtr_wvalue      = comm_ptr.value;
    assign bus.io_commPtrPlus1_wvalue = comm_ptr_p1.value;
    assign bus.io_ifu_req_valid       = ifu_req_valid;
    assign bus.io_count               = bpu_ptr - comm_ptr;
endmodule

// File: tb/tb_ftq_pc_mem_writer.sv
// Directed bench for ftq_pc_mem_writer: vector table for enqueue/full behaviour plus hand sequences
// for wrap, IFU stepping, redirect rollback and asynchronous reset.
module tb_ftq_pc_mem_writer;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    ftq_pc_mem_writer_if bus ();
    ftq_pc_mem_writer dut (.clock(clock), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        enq;
        logic [38:0] st;
        logic [38:0] nx;
        logic        fte;
        logic        fire;
        logic        cm;
        logic        e_wen;
        logic [2:0]  e_waddr;
        logic [38:0] e_st;
        logic [38:0] e_nx;
        logic        e_fte;
        logic [3:0]  e_cnt;
        logic        e_rdy;
        logic        e_rv;
        logic [2:0]  e_ifu;
        logic [2:0]  e_comm;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mk(input int enq, input longint st, input longint nx, input int fte,
                                input int fire, input int cm, input int e_wen, input int e_waddr,
                                input longint e_st, input longint e_nx, input int e_fte,
                                input int e_cnt, input int e_rdy, input int e_rv,
                                input int e_ifu, input int e_comm);
        vec_t v;
        v.enq = 1'(enq);      v.st = 39'(st);       v.nx = 39'(nx);     v.fte = 1'(fte);
        v.fire = 1'(fire);    v.cm = 1'(cm);        v.e_wen = 1'(e_wen);
        v.e_waddr = 3'(e_waddr); v.e_st = 39'(e_st); v.e_nx = 39'(e_nx); v.e_fte = 1'(e_fte);
        v.e_cnt = 4'(e_cnt);  v.e_rdy = 1'(e_rdy);  v.e_rv = 1'(e_rv);
        v.e_ifu = 3'(e_ifu);  v.e_comm = 3'(e_comm);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.io_enq_valid         = 1'b0;
        bus.io_enq_startAddr     = '0;
        bus.io_enq_nextLineAddr  = '0;
        bus.io_enq_fallThruError = 1'b0;
        bus.io_ifu_fire          = 1'b0;
        bus.io_commit_valid      = 1'b0;
        bus.io_redirect_valid    = 1'b0;
        bus.io_redirect_flag     = 1'b0;
        bus.io_redirect_value    = '0;
    endtask

    // Drive one cycle of inputs, let the edge take them, then return inputs to idle before checking.
    task automatic cyc(input logic enq, input logic [38:0] st, input logic [38:0] nx, input logic fte,
                       input logic fire, input logic cm, input logic rd, input logic rf,
                       input logic [2:0] rv);
        bus.io_enq_valid         = enq;
        bus.io_enq_startAddr     = st;
        bus.io_enq_nextLineAddr  = nx;
        bus.io_enq_fallThruError = fte;
        bus.io_ifu_fire          = fire;
        bus.io_commit_valid      = cm;
        bus.io_redirect_valid    = rd;
        bus.io_redirect_flag     = rf;
        bus.io_redirect_value    = rv;
        @(posedge clock);
        #1;
        idle();
        #1;
    endtask

    task automatic enq1(input logic [38:0] st);
        cyc(1'b1, st, st + 39'h40, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic step(input logic fire, input logic cm);
        cyc(1'b0, '0, '0, 1'b0, fire, cm, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic chk_ptrs(input string tag, input int i0, input int i1, input int i2,
                            input int c0, input int c1);
        chk({tag, "/ifuPtr"},       64'(bus.io_ifuPtr_wvalue),       64'(i0));
        chk({tag, "/ifuPtrPlus1"},  64'(bus.io_ifuPtrPlus1_wvalue),  64'(i1));
        chk({tag, "/ifuPtrPlus2"},  64'(bus.io_ifuPtrPlus2_wvalue),  64'(i2));
        chk({tag, "/commPtr"},      64'(bus.io_commPtr_wvalue),      64'(c0));
        chk({tag, "/commPtrPlus1"}, 64'(bus.io_commPtrPlus1_wvalue), 64'(c1));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
    endtask

    initial begin
        vt[0]  = mk(0, 'h0,    'h0,    0, 0, 0,  0, 0, 'h0,    'h0,    0,  0, 1, 0, 0, 0);
        vt[1]  = mk(1, 'h1000, 'h1040, 0, 0, 0,  1, 0, 'h1000, 'h1040, 0,  1, 1, 0, 0, 0);
        vt[2]  = mk(0, 'h0,    'h0,    0, 0, 0,  0, 0, 'h1000, 'h1040, 0,  1, 1, 1, 0, 0);
        vt[3]  = mk(1, 'h1100, 'h1140, 1, 0, 0,  1, 1, 'h1100, 'h1140, 1,  2, 1, 1, 0, 0);
        vt[4]  = mk(1, 'h1200, 'h1240, 0, 0, 0,  1, 2, 'h1200, 'h1240, 0,  3, 1, 1, 0, 0);
        vt[5]  = mk(1, 'h1300, 'h1340, 1, 0, 0,  1, 3, 'h1300, 'h1340, 1,  4, 1, 1, 0, 0);
        vt[6]  = mk(1, 'h1400, 'h1440, 0, 0, 0,  1, 4, 'h1400, 'h1440, 0,  5, 1, 1, 0, 0);
        vt[7]  = mk(1, 'h1500, 'h1540, 1, 0, 0,  1, 5, 'h1500, 'h1540, 1,  6, 1, 1, 0, 0);
        vt[8]  = mk(1, 'h1600, 'h1640, 0, 0, 0,  1, 6, 'h1600, 'h1640, 0,  7, 1, 1, 0, 0);
        vt[9]  = mk(1, 'h1700, 'h1740, 1, 0, 0,  1, 7, 'h1700, 'h1740, 1,  8, 0, 1, 0, 0);
        vt[10] = mk(1, 'h7777, 'h7777, 1, 0, 0,  0, 7, 'h1700, 'h1740, 1,  8, 0, 1, 0, 0);
        vt[11] = mk(0, 'h0,    'h0,    0, 1, 0,  0, 7, 'h1700, 'h1740, 1,  8, 0, 1, 1, 0);
        vt[12] = mk(1, 'h8888, 'h8888, 1, 0, 1,  0, 7, 'h1700, 'h1740, 1,  7, 1, 1, 1, 1);
        vt[13] = mk(1, 'h9000, 'h9040, 0, 0, 0,  1, 0, 'h9000, 'h9040, 0,  8, 0, 1, 1, 1);

        reset = 1'b1;
        idle();
        #1 reset = 1'b0;
        #3;
        chk("rst/wen",   64'(bus.io_wen),           64'(0));
        chk("rst/waddr", 64'(bus.io_waddr),         64'(0));
        chk("rst/count", 64'(bus.io_count),         64'(0));
        chk("rst/ready", 64'(bus.io_enq_ready),     64'(1));
        chk("rst/reqv",  64'(bus.io_ifu_req_valid), 64'(0));
        chk("rst/wdata", 64'(bus.io_wdata_startAddr), 64'(0));
        chk_ptrs("rst", 0, 1, 2, 0, 1);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;

        for (int i = 0; i < 14; i++) begin
            cyc(vt[i].enq, vt[i].st, vt[i].nx, vt[i].fte, vt[i].fire, vt[i].cm,
                1'b0, 1'b0, 3'd0);
            chk($sformatf("vec%0d/wen", i),   64'(bus.io_wen),                 64'(vt[i].e_wen));
            chk($sformatf("vec%0d/waddr", i), 64'(bus.io_waddr),               64'(vt[i].e_waddr));
            chk($sformatf("vec%0d/start", i), 64'(bus.io_wdata_startAddr),     64'(vt[i].e_st));
            chk($sformatf("vec%0d/next", i),  64'(bus.io_wdata_nextLineAddr),  64'(vt[i].e_nx));
            chk($sformatf("vec%0d/fte", i),   64'(bus.io_wdata_fallThruError), 64'(vt[i].e_fte));
            chk($sformatf("vec%0d/count", i), 64'(bus.io_count),               64'(vt[i].e_cnt));
            chk($sformatf("vec%0d/ready", i), 64'(bus.io_enq_ready),           64'(vt[i].e_rdy));
            chk($sformatf("vec%0d/reqv", i),  64'(bus.io_ifu_req_valid),       64'(vt[i].e_rv));
            chk($sformatf("vec%0d/ifu", i),   64'(bus.io_ifuPtr_wvalue),       64'(vt[i].e_ifu));
            chk($sformatf("vec%0d/comm", i),  64'(bus.io_commPtr_wvalue),      64'(vt[i].e_comm));
        end

        // Full pointer wrap: the ninth allocation lands back in slot 0 with the flag set.
        do_reset();
        for (int i = 0; i < 8; i++) enq1(39'h2000 + 39'(i) * 39'h100);
        step(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        chk("wrap/reqv_drained", 64'(bus.io_ifu_req_valid), 64'(0));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        chk("wrap/count_empty", 64'(bus.io_count), 64'(0));
        enq1(39'h3000);
        chk("wrap/wen",    64'(bus.io_wen),     64'(1));
        chk("wrap/waddr",  64'(bus.io_waddr),   64'(0));
        chk("wrap/bpuPtr", 64'(dut.bpu_ptr),    64'(4'h9));
        chk("wrap/count",  64'(bus.io_count),   64'(1));
        chk_ptrs("wrap", 0, 1, 2, 0, 1);

        // IFU stepping across the wrap, then a fire with nothing readable.
        do_reset();
        for (int i = 0; i < 8; i++) enq1(39'h4000 + 39'(i) * 39'h100);
        step(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        chk_ptrs("ifu6", 6, 7, 0, 0, 1);
        chk("ifu6/reqv", 64'(bus.io_ifu_req_valid), 64'(1));
        step(1'b1, 1'b0);
        chk_ptrs("ifu7", 7, 0, 1, 0, 1);
        step(1'b1, 1'b0);
        chk_ptrs("ifu8", 0, 1, 2, 0, 1);
        chk("ifu8/reqv", 64'(bus.io_ifu_req_valid), 64'(0));
        step(1'b1, 1'b0);
        chk_ptrs("ifu_nofire", 0, 1, 2, 0, 1);

        // Redirect at {0,2} with 5 enqueued, ifuPtr=4, commPtr=1.
        do_reset();
        for (int i = 0; i < 5; i++) enq1(39'h5000 + 39'(i) * 39'h100);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        chk_ptrs("pre_redir", 4, 5, 6, 1, 2);
        chk("pre_redir/count", 64'(bus.io_count), 64'(4));
        cyc(1'b1, 39'h6000, 39'h6040, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2);
        chk("redir/wen",    64'(bus.io_wen),           64'(0));
        chk("redir/bpuPtr", 64'(dut.bpu_ptr),          64'(4'h3));
        chk("redir/count",  64'(bus.io_count),         64'(2));
        chk("redir/reqv",   64'(bus.io_ifu_req_valid), 64'(0));
        chk("redir/ready",  64'(bus.io_enq_ready),     64'(1));
        chk_ptrs("redir", 3, 4, 5, 1, 2);

        // Asynchronous reset while a write is being presented.
        enq1(39'h7000);
        chk("arst/wen_before",   64'(bus.io_wen),   64'(1));
        chk("arst/waddr_before", 64'(bus.io_waddr), 64'(3));
        #1 reset = 1'b0;
        #1;
        chk("arst/wen",   64'(bus.io_wen),   64'(0));
        chk("arst/count", 64'(bus.io_count), 64'(0));
        chk_ptrs("arst", 0, 1, 2, 0, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst/ready", 64'(bus.io_enq_ready), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ftq_pc_mem_writer.md
Name: ftq_pc_mem_writer

Overview:
- Enqueue and pointer-control side of the 8-entry FTQ PC memory.
- Accepts BPU predictions through a valid/ready handshake and allocates circular-queue slots.
- Issues registered write requests (wen/waddr/wdata) into the PC memory.
- Maintains the ifu and commit pointer families, which drive the memory's read addresses, and handles backend redirect rollback.

Parameters:
- ENTRIES, 8: queue depth, power of two; pointer = 1 flag bit + log2(ENTRIES) value bits.
- VADDR_W, 39: address width.

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low (asserted at 0)
- io_enq_valid  in  1  BPU prediction valid
- io_enq_ready  out  1  slot available
- io_enq_startAddr  in  39  block start PC
- io_enq_nextLineAddr  in  39  next cache-line PC
- io_enq_fallThruError  in  1  fall-through error flag
- io_ifu_fire  in  1  IFU consumed the entry at ifuPtr
- io_commit_valid  in  1  backend retires the entry at commPtr
- io_redirect_valid  in  1  backend redirect
- io_redirect_flag  in  1  redirect pointer flag
- io_redirect_value  in  3  redirect pointer value
- io_wen  out  1  PC memory write enable
- io_waddr  out  3  PC memory write address
- io_wdata_startAddr  out  39  write data
- io_wdata_nextLineAddr  out  39  write data
- io_wdata_fallThruError  out  1  write data
- io_ifuPtr_wvalue  out  3  read address, ifuPtr
- io_ifuPtrPlus1_wvalue  out  3  read address, ifuPtr+1
- io_ifuPtrPlus2_wvalue  out  3  read address, ifuPtr+2
- io_commPtr_wvalue  out  3  read address, commPtr
- io_commPtrPlus1_wvalue  out  3  read address, commPtr+1
- io_ifu_req_valid  out  1  entry at ifuPtr written and readable
- io_count  out  4  occupied entries, 0..8

Behaviour:
- Registered state:
  - bpuPtr, wbPtr, ifuPtr, ifuPtrPlus1, ifuPtrPlus2, commPtr, commPtrPlus1 (each flag + value).
  - Write stage: wen, waddr, wdata.
- Reset values (async, while reset=0):
  - All pointers flag=0 with value 0, except ifuPtrPlus1=1, ifuPtrPlus2=2, commPtrPlus1=1.
  - io_wen=0, io_waddr=0, wdata=0.
  - Resulting outputs: io_count=0, io_ifu_req_valid=0, io_enq_ready=1.
- Pointer arithmetic: add modulo 8; the flag toggles on wrap from 7 to 0.
- count = bpuPtr − commPtr.
  - full when count=8: values equal, flags differ.
  - empty when count=0: pointers identical.
- io_enq_ready = !full && !io_redirect_valid. It is a function of current state only; a same-cycle commit does not open a slot.
- Enqueue fire (valid&&ready) at cycle T:
  - bpuPtr += 1.
  - Write stage loads wen=1, waddr=old bpuPtr.value, wdata=inputs.
  - io_wen=1 during T+1.
  - With no fire, wen=0 next cycle.
- wbPtr <= bpuPtr each cycle, i.e. it lags one cycle and marks slots whose write has been issued.
- io_ifu_req_valid = (ifuPtr != wbPtr). The entry is therefore first readable at T+2 relative to enqueue.
- IFU advance:
  - Taken when io_ifu_fire && io_ifu_req_valid.
  - ifuPtr, ifuPtrPlus1 and ifuPtrPlus2 all += 1.
  - io_ifu_fire while req_valid=0 is ignored.
- Commit:
  - Taken when io_commit_valid && commPtr != ifuPtr.
  - commPtr and commPtrPlus1 += 1.
  - Otherwise ignored.
- Redirect (io_redirect_valid=1), where R = {flag,value} and N = R+1:
  - bpuPtr, wbPtr and ifuPtr are set to N.
  - ifuPtrPlus1=N+1, ifuPtrPlus2=N+2.
  - Redirect wins over ifu_fire in the same cycle; no enqueue occurs that cycle.
  - A commit in the same cycle is still applied.
  - A write stage already loaded completes. Its slot is beyond N and is rewritten later.
  - Legal only for R in [commPtr, bpuPtr); any other R leaves the block in an undefined state.
- Plus-pointers are kept as separate registers, never added combinationally at the outputs. Read-address outputs are the value fields of those registers.
- Reset asserted mid-operation: all state returns to reset values immediately; any in-flight write is dropped (io_wen=0).

Test Plan:
- Reset release, enq one entry (start=0x1000, next=0x1040, fte=0) at T:
  - io_wen=1, waddr=0 and wdata match at T+1.
  - io_ifu_req_valid=1 at T+2.
  - io_count=1 from T+1.
- Eight back-to-back enqueues with no commit:
  - waddr sequence 0..7.
  - io_count=8 and io_enq_ready=0 after the 8th.
  - A 9th valid is held off.
  - With full and commit asserted in the same cycle, no enqueue that cycle; ready=1 next cycle.
- Wrap check:
  - Enqueue 8, IFU-fire 8, commit 8, enqueue 1.
  - waddr=0; bpuPtr flag=1; count=1.
  - io_commPtr_wvalue=0, io_commPtrPlus1_wvalue=1.
- IFU stepping with ifuPtr=6:
  - Outputs 6/7/0.
  - After one fire: 7/0/1.
  - Fire with req_valid=0: pointers unchanged.
- Redirect:
  - Setup: 5 entries enqueued, ifuPtr=4, commPtr=1.
  - Redirect with R={0,2}, plus simultaneous ifu_fire and enq_valid.
  - Next cycle: bpuPtr=ifuPtr=3, ifuPtrPlus1=4, ifuPtrPlus2=5, count=2, io_ifu_req_valid=0.
  - No write is issued for the blocked enqueue.
- Reset asserted while io_wen=1:
  - io_wen drops to 0 asynchronously.
  - All pointer outputs return to reset values (0,1,2,0,1).
  - io_enq_ready=1 after release.
